sensor_sweep_uc: RTL and testbench
==================================

// Module: sensor_sweep_uc
// PURPOSE
//  Parametrised control unit that sweeps N sensors: triggers one measurement, waits with a timeout until
//  every sensor reports ready, then sends BYTES_PER_SENSOR serial bytes per sensor in order. It has
//  internal sensor/byte counters, a continuous mode, and a TX watchdog with a sticky error state.
//  Sits between the sensor interfaces, the data mux (driven by sel_sensor/sel_byte) and serial TX.
// PARAMETERS
//  N_SENSORS        3     number of sensors swept (>=1)
//  BYTES_PER_SENSOR 4     serial bytes sent per sensor (>=1)
//  SETTLE_CYCLES    1000  max cycles waiting for all pronto_medida before error (>=2)
//  TX_TIMEOUT       5000  max cycles waiting for pronto_serial per byte before error (>=2)
//  (local) SW=max(1,clog2(N_SENSORS)), BW=max(1,clog2(BYTES_PER_SENSOR))
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-high
//  jogar          in   1   start sweep (level); also clears ERRO
//  continuo       in   1   1 = restart sweep automatically after FINAL
//  pronto_medida  in   N   per-sensor measurement done pulses/levels
//  pronto_serial  in   1   serial TX finished current byte
//  medir          out  1   one-cycle measurement trigger to all sensors
//  partida_tx     out  1   one-cycle serial start pulse
//  sel_sensor     out  SW  sensor index selecting data mux
//  sel_byte       out  BW  byte index within current sensor
//  pronto         out  1   one-cycle pulse: full sweep sent
//  erro           out  1   held high while in ERRO
//  erro_cod       out  2   00 none, 01 measurement timeout, 10 TX timeout; held until ERRO exits
//  db_estado      out  4   state code (below)
// BEHAVIOUR
//  - Reset (sync, wins over all): state INICIAL, all outputs 0, counters/latches 0.
//  - Moore outputs decoded from registered state; sel_* are the counter registers.
//  - States (db_estado): INICIAL 0, MEDIR 1, ESPERA 2, ENVIA 3, AGUARDA_TX 4, PROX 5, FINAL 6, ERRO F.
//  - INICIAL: sensor=byte=0, timers 0, erro_cod=00; jogar=1 -> MEDIR.
//  - MEDIR: medir=1 exactly one cycle; clears lat[N-1:0] and settle timer -> ESPERA.
//  - ESPERA: lat[i] |= pronto_medida[i] each cycle; settle timer +1/cycle.
//    &(lat|pronto_medida) -> ENVIA (same-cycle pulses count). Else timer==SETTLE_CYCLES-1 -> ERRO, cod 01.
//    Success and timeout in same cycle: success wins.
//  - ENVIA: partida_tx=1 one cycle; clears TX timer -> AGUARDA_TX.
//  - AGUARDA_TX: timer +1/cycle; pronto_serial -> PROX; else timer==TX_TIMEOUT-1 -> ERRO, cod 10.
//    pronto_serial on the timeout cycle: success wins. pronto_serial outside AGUARDA_TX is ignored.
//  - PROX (one cycle): byte<BYTES_PER_SENSOR-1: byte+1 -> ENVIA.
//    Else byte=0; sensor<N_SENSORS-1: sensor+1 -> ENVIA; else -> FINAL.
//  - FINAL: pronto=1 one cycle; sensor=byte=0; continuo=1 -> MEDIR, else -> INICIAL.
//    continuo is sampled only in FINAL; changes mid-sweep have no effect.
//  - ERRO: erro=1, erro_cod held, counters frozen; jogar=1 -> INICIAL (clears erro next cycle).
//    jogar held high from ERRO therefore restarts after INICIAL (2 cycles).
//  - jogar is ignored outside INICIAL and ERRO.
//  - Unused state encodings -> INICIAL.
//  - Latency, N=3,B=4, sensors ready 1 cycle after medir, pronto_serial 1 cycle after partida_tx:
//    jogar -> first partida_tx = 3 cycles; each byte = 3 cycles (ENVIA, AGUARDA_TX, PROX).
// TESTING
//  1. Nominal, N=3,B=4: jogar pulse, all sensors ready, pronto_serial 2 cycles after each partida_tx
//     -> 12 partida_tx with (sel_sensor,sel_byte) 0,0..2,3 in order; one pronto; back to INICIAL.
//  2. Sensor 2 never ready, SETTLE_CYCLES=8 -> ERRO entered 8 cycles after ESPERA entry, erro=1, cod=01,
//     no partida_tx; then jogar -> INICIAL, erro=0, cod=00.
//  3. pronto_serial withheld on byte 5, TX_TIMEOUT=16 -> ERRO with cod=10, sel_sensor=1, sel_byte=1 frozen.
//  4. continuo=1 -> after pronto, medir reasserts next cycle; drop continuo mid-sweep
//     -> that sweep completes, then INICIAL.
//  5. Staggered pronto_medida pulses (sensor0 c1, sensor1 c4, sensor2 c7) -> ENVIA only after c7.
//     Success coinciding with the last timeout cycle -> ENVIA, not ERRO.
//  6. reset asserted in AGUARDA_TX -> next cycle INICIAL, all outputs 0; N=1,B=1 build -> 1 byte sent, then pronto.

Source files
------------

// File: rtl/sensor_sweep_uc.sv
// Sweep controller: triggers one measurement on all sensors, waits for every ready flag,
// then streams BYTES_PER_SENSOR serial bytes per sensor, with settle/TX watchdogs.
module sensor_sweep_uc #(
  parameter int N_SENSORS        = 3,
  parameter int BYTES_PER_SENSOR = 4,
  parameter int SETTLE_CYCLES    = 1000,
  parameter int TX_TIMEOUT       = 5000,
  localparam int SW   = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1,
  localparam int BW   = (BYTES_PER_SENSOR > 1) ? $clog2(BYTES_PER_SENSOR) : 1,
  localparam int TMAX = (SETTLE_CYCLES > TX_TIMEOUT) ? SETTLE_CYCLES : TX_TIMEOUT,
  localparam int TW   = $clog2(TMAX)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 jogar_i,
  input  logic                 continuo_i,
  input  logic [N_SENSORS-1:0] pronto_medida_i,
  input  logic                 pronto_serial_i,
  output logic                 medir_o,
  output logic                 partida_tx_o,
  output logic [SW-1:0]        sel_sensor_o,
  output logic [BW-1:0]        sel_byte_o,
  output logic                 pronto_o,
  output logic                 erro_o,
  output logic [1:0]           erro_cod_o,
  output logic [3:0]           db_estado_o
);

  typedef enum logic [3:0] {
    S_INICIAL    = 4'h0,
    S_MEDIR      = 4'h1,
    S_ESPERA     = 4'h2,
    S_ENVIA      = 4'h3,
    S_AGUARDA_TX = 4'h4,
    S_PROX       = 4'h5,
    S_FINAL      = 4'h6,
    S_ERRO       = 4'hF
  } state_t;

  state_t               state_q;
  logic [SW-1:0]        sensor_q;
  logic [BW-1:0]        byte_q;
  logic [N_SENSORS-1:0] lat_q;
  logic [TW-1:0]        timer_q;
  logic [1:0]           erro_cod_q;

  // A ready pulse arriving in the same cycle as the check still counts.
  logic all_ready;
  assign all_ready = &(lat_q | pronto_medida_i);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_INICIAL;
      sensor_q   <= '0;
      byte_q     <= '0;
      lat_q      <= '0;
      timer_q    <= '0;
      erro_cod_q <= 2'b00;
    end else begin
      case (state_q)
        S_INICIAL: begin
          sensor_q   <= '0;
          byte_q     <= '0;
          timer_q    <= '0;
          erro_cod_q <= 2'b00;
          if (jogar_i) state_q <= S_MEDIR;
        end
        S_MEDIR: begin
          lat_q   <= '0;
          timer_q <= '0;
          state_q <= S_ESPERA;
        end
        S_ESPERA: begin
          lat_q   <= lat_q | pronto_medida_i;
          timer_q <= timer_q + TW'(1);
          if (all_ready) begin
            state_q <= S_ENVIA;
          end else if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
            state_q    <= S_ERRO;
            erro_cod_q <= 2'b01;
          end
        end
        S_ENVIA: begin
          timer_q <= '0;
          state_q <= S_AGUARDA_TX;
        end
        S_AGUARDA_TX: begin
          timer_q <= timer_q + TW'(1);
          if (pronto_serial_i) begin
            state_q <= S_PROX;
          end else if (timer_q == TW'(TX_TIMEOUT - 1)) begin
            state_q    <= S_ERRO;
            erro_cod_q <= 2'b10;
          end
        end
        S_PROX: begin
          if (byte_q != BW'(BYTES_PER_SENSOR - 1)) begin
            byte_q  <= byte_q + BW'(1);
            state_q <= S_ENVIA;
          end else begin
            byte_q <= '0;
            if (sensor_q != SW'(N_SENSORS - 1)) begin
              sensor_q <= sensor_q + SW'(1);
              state_q  <= S_ENVIA;
            end else begin
              state_q <= S_FINAL;
            end
          end
        end
        S_FINAL: begin
          sensor_q <= '0;
          byte_q   <= '0;
          state_q  <= continuo_i ? S_MEDIR : S_INICIAL;
        end
        // Counters stay frozen so the failing sensor/byte remains visible.
        S_ERRO: begin
          if (jogar_i) begin
            state_q    <= S_INICIAL;
            erro_cod_q <= 2'b00;
          end
        end
        default: state_q <= S_INICIAL;
      endcase
    end
  end

  assign medir_o      = (state_q == S_MEDIR);
  assign partida_tx_o = (state_q == S_ENVIA);
  assign pronto_o     = (state_q == S_FINAL);
  assign erro_o       = (state_q == S_ERRO);
  assign erro_cod_o   = erro_cod_q;
  assign sel_sensor_o = sensor_q;
  assign sel_byte_o   = byte_q;
  assign db_estado_o  = state_q;

endmodule

// File: tb/tb_sensor_sweep_uc.sv
// Bench for sensor_sweep_uc: scoreboard of expected (sensor,byte) per partida_tx,
// plus directed timing checks on errors, continuous mode and reset.
module tb_sensor_sweep_uc;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic       continuo = 1'b0;
  logic [2:0] pronto_medida = '0;
  logic       pronto_serial = 1'b0;
  logic       medir, partida_tx, pronto, erro;
  logic [1:0] sel_sensor, sel_byte, erro_cod;
  logic [3:0] db_estado;

  // Minimal N=1,B=1 build
  logic       jogar1 = 1'b0;
  logic       pm1 = 1'b1;
  logic       ps1 = 1'b1;
  logic       medir1, partida1, pronto1, erro1;
  logic [0:0] sel_s1, sel_b1;
  logic [1:0] cod1;
  logic [3:0] est1;

  always #5 clock = ~clock;

  sensor_sweep_uc #(.N_SENSORS(3), .BYTES_PER_SENSOR(4), .SETTLE_CYCLES(8), .TX_TIMEOUT(16)) u_dut (
    .clock_i(clock), .reset_i(reset), .jogar_i(jogar), .continuo_i(continuo),
    .pronto_medida_i(pronto_medida), .pronto_serial_i(pronto_serial),
    .medir_o(medir), .partida_tx_o(partida_tx), .sel_sensor_o(sel_sensor), .sel_byte_o(sel_byte),
    .pronto_o(pronto), .erro_o(erro), .erro_cod_o(erro_cod), .db_estado_o(db_estado));

  sensor_sweep_uc #(.N_SENSORS(1), .BYTES_PER_SENSOR(1), .SETTLE_CYCLES(8), .TX_TIMEOUT(16)) u_dut1 (
    .clock_i(clock), .reset_i(reset), .jogar_i(jogar1), .continuo_i(1'b0),
    .pronto_medida_i(pm1), .pronto_serial_i(ps1),
    .medir_o(medir1), .partida_tx_o(partida1), .sel_sensor_o(sel_s1), .sel_byte_o(sel_b1),
    .pronto_o(pronto1), .erro_o(erro1), .erro_cod_o(cod1), .db_estado_o(est1));

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int med_dly[3];
  int med_cnt[3];
  int ps_cnt = 0;
  int tx_idx = 0;
  int withhold_idx = -1;
  int late_idx = -1;
  int tx_cnt = 0, pronto_cnt = 0, medir_cnt = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_until(input logic [3:0] st, input int budget, output int n);
    n = 0;
    while (db_estado !== st && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic push_sweep();
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back((s << 2) | b);
  endtask

  task automatic start_sweep();
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    tx_idx = 0;
    withhold_idx = -1;
    late_idx = -1;
    ps_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      med_cnt[i] = 0;
      med_dly[i] = 1;
    end
  endtask

  // Sensor/serial responders and the partida_tx scoreboard
  initial begin
    logic [2:0] pm;
    int e;
    forever begin
      tick();
      pronto_serial = 1'b0;
      if (ps_cnt > 0) begin
        ps_cnt--;
        if (ps_cnt == 0) pronto_serial = 1'b1;
      end
      pm = '0;
      for (int i = 0; i < 3; i++) begin
        if (med_cnt[i] > 0) begin
          med_cnt[i]--;
          if (med_cnt[i] == 0) pm[i] = 1'b1;
        end
      end
      pronto_medida = pm;
      if (medir) begin
        medir_cnt++;
        for (int i = 0; i < 3; i++) med_cnt[i] = med_dly[i];
      end
      if (partida_tx) begin
        tx_cnt++;
        if (exp_q.size() == 0) begin
          chk("tx_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_sel", int'({sel_sensor, sel_byte}), e);
        end
        if (tx_idx == late_idx) ps_cnt = 16;
        else if (tx_idx != withhold_idx) ps_cnt = 2;
        tx_idx++;
      end
      if (pronto) pronto_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, tx0, pr0, me0;
    do_reset();

    chk("reset_state", int'(db_estado), 0);
    chk("reset_outs", int'({medir, partida_tx, pronto, erro, erro_cod, sel_sensor, sel_byte}), 0);

    // Nominal sweep
    tx0 = tx_cnt; pr0 = pronto_cnt;
    push_sweep();
    start_sweep();
    chk("nom_medir_state", int'(db_estado), 1);
    chk("nom_medir_out", int'(medir), 1);
    run_until(4'h6, 300, n);
    chk("nom_final_cycles", n, 50);
    tick();
    chk("nom_back_inicial", int'(db_estado), 0);
    tick();
    chk("nom_tx_count", tx_cnt - tx0, 12);
    chk("nom_pronto_count", pronto_cnt - pr0, 1);
    chk("nom_queue_empty", exp_q.size(), 0);

    // Settle timeout, sensor 2 never ready
    do_reset();
    med_dly[2] = 0;
    tx0 = tx_cnt;
    start_sweep();
    run_until(4'hF, 300, n);
    chk("settle_err_cycles", n, 9);
    chk("settle_erro", int'(erro), 1);
    chk("settle_cod", int'(erro_cod), 1);
    tick(); tick(); tick();
    chk("settle_cod_held", int'(erro_cod), 1);
    chk("settle_state_held", int'(db_estado), 15);
    chk("settle_no_tx", tx_cnt - tx0, 0);
    start_sweep();
    chk("settle_clr_state", int'(db_estado), 0);
    chk("settle_clr_erro", int'(erro), 0);
    chk("settle_clr_cod", int'(erro_cod), 0);

    // TX timeout on byte 5 (sensor 1, byte 1)
    do_reset();
    withhold_idx = 5;
    for (int k = 0; k < 6; k++) exp_q.push_back(((k / 4) << 2) | (k % 4));
    start_sweep();
    run_until(4'hF, 300, n);
    chk("tx_err_cycles", n, 39);
    chk("tx_err_cod", int'(erro_cod), 2);
    tick(); tick();
    chk("tx_err_sensor", int'(sel_sensor), 1);
    chk("tx_err_byte", int'(sel_byte), 1);
    chk("tx_err_erro", int'(erro), 1);
    chk("tx_queue_empty", exp_q.size(), 0);
    start_sweep();
    chk("tx_clr_cod", int'(erro_cod), 0);

    // Continuous mode, dropped mid-sweep
    do_reset();
    continuo = 1'b1;
    pr0 = pronto_cnt; me0 = medir_cnt;
    push_sweep();
    push_sweep();
    start_sweep();
    run_until(4'h6, 300, n);
    chk("cont_first_final", n, 50);
    tick();
    chk("cont_remedir_state", int'(db_estado), 1);
    chk("cont_remedir_out", int'(medir), 1);
    for (int k = 0; k < 5; k++) tick();
    continuo = 1'b0;
    run_until(4'h6, 300, n);
    chk("cont_second_final", n, 45);
    tick();
    chk("cont_end_inicial", int'(db_estado), 0);
    tick(); tick();
    chk("cont_end_state", int'(db_estado), 0);
    chk("cont_pronto_count", pronto_cnt - pr0, 2);
    chk("cont_medir_count", medir_cnt - me0, 2);
    chk("cont_queue_empty", exp_q.size(), 0);

    // Staggered ready pulses; first byte answered on the last TX timeout cycle
    do_reset();
    med_dly[0] = 1; med_dly[1] = 4; med_dly[2] = 7;
    late_idx = 0;
    push_sweep();
    start_sweep();
    run_until(4'h3, 300, n);
    chk("stag_envia_cycles", n, 8);
    run_until(4'h6, 300, n);
    chk("stag_final_cycles", n, 62);
    tick();
    chk("stag_queue_empty", exp_q.size(), 0);

    // Ready on the last settle cycle, then reset during AGUARDA_TX
    do_reset();
    med_dly[0] = 1; med_dly[1] = 1; med_dly[2] = 8;
    push_sweep();
    start_sweep();
    run_until(4'h3, 300, n);
    chk("edge_envia_cycles", n, 9);
    tick();
    chk("edge_aguarda", int'(db_estado), 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_state", int'(db_estado), 0);
    chk("rst_outs", int'({medir, partida_tx, pronto, erro, erro_cod, sel_sensor, sel_byte}), 0);
    exp_q.delete();
    tick(); tick();
    chk("rst_ignore_serial", int'(db_estado), 0);

    // N=1, B=1 build
    tx0 = 0;
    jogar1 = 1'b1;
    tick();
    jogar1 = 1'b0;
    n = 0;
    while (est1 !== 4'h6 && n < 100) begin
      if (partida1) begin
        tx0++;
        chk("one_sel", int'({sel_s1, sel_b1}), 0);
      end
      tick();
      n++;
    end
    chk("one_final_cycles", n, 5);
    chk("one_tx_count", tx0, 1);
    chk("one_pronto", int'(pronto1), 1);
    tick();
    chk("one_back_inicial", int'(est1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
